// File: rtl/lector_memoria_pixeles.sv
// Frame-memory reader for buffer_pixeles_mem: one read outstanding, 4 pixels per 32-bit word, save strobe the cycle after mem_ready.
// Backpressure: a new request is issued only while the credit (pixels held downstream) is <= 4, so the two-word buffer never overflows.
module lector_memoria_pixeles #(
  parameter int          ADDR_WIDTH = 18,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned NUM_WORDS  = 16384
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [31:0]           mem_data_in,
  input  logic                  mem_ready,
  output logic [31:0]           memory_data,
  output logic                  save_mem_data,
  input  logic                  read_pixel,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun
);

  localparam int                    CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0]      LAST_WORD = CNT_W'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, SAVE, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              credit, credit_nxt;
  logic [CNT_W-1:0]        word_cnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    start_ok;
  logic                    consume;

  always_comb begin
    state_nxt     = state;
    mem_rd        = 1'b0;
    save_mem_data = 1'b0;
    done          = 1'b0;
    start_ok      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (credit <= 4'd4) begin
          mem_rd    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem_ready) state_nxt = SAVE;
      end
      SAVE: begin
        save_mem_data = 1'b1;
        state_nxt     = (word_cnt == LAST_WORD) ? DRAIN : REQ;
      end
      DRAIN: begin
        if (credit == 4'd0) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // busy drops in the same cycle done pulses
  assign busy     = (state != IDLE) && !done;
  assign mem_addr = addr;

  // A read at zero credit is an underrun and must not wrap the counter
  assign consume    = read_pixel && (credit != 4'd0);
  assign credit_nxt = credit + (save_mem_data ? 4'd4 : 4'd0) - (consume ? 4'd1 : 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      credit      <= 4'd0;
      word_cnt    <= '0;
      addr        <= BASE;
      memory_data <= 32'd0;
      underrun    <= 1'b0;
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
      if (start_ok) begin
        word_cnt <= '0;
        addr     <= BASE;
      end else if (save_mem_data) begin
        word_cnt <= word_cnt + CNT_W'(1);
        addr     <= addr + ADDR_WIDTH'(1);
      end
      if (state == WAIT && mem_ready) memory_data <= mem_data_in;
      if (start_ok) underrun <= 1'b0;
      else if (read_pixel && credit == 4'd0) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lector_memoria_pixeles.sv
// Directed bench: instance a runs 2-word frames, instance b runs 4-word frames; sel picks which one is observed.
module tb_lector_memoria_pixeles;
  localparam int AW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start_a, start_b, mem_ready, read_pixel, sel;
  logic [31:0]   mem_data_in;
  logic [AW-1:0] a_addr, b_addr, o_addr;
  logic [31:0]   a_md, b_md, o_md;
  logic a_rd, a_save, a_busy, a_done, a_und;
  logic b_rd, b_save, b_busy, b_done, b_und;
  logic o_rd, o_save, o_busy, o_done, o_und;

  int checks = 0, errors = 0, save_cnt = 0, done_cnt = 0;

  lector_memoria_pixeles #(.ADDR_WIDTH(AW), .BASE_ADDR(0), .NUM_WORDS(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .mem_addr(a_addr), .mem_rd(a_rd),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready), .memory_data(a_md),
    .save_mem_data(a_save), .read_pixel(read_pixel), .busy(a_busy), .done(a_done),
    .underrun(a_und));

  lector_memoria_pixeles #(.ADDR_WIDTH(AW), .BASE_ADDR(0), .NUM_WORDS(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mem_addr(b_addr), .mem_rd(b_rd),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready), .memory_data(b_md),
    .save_mem_data(b_save), .read_pixel(read_pixel), .busy(b_busy), .done(b_done),
    .underrun(b_und));

  assign o_addr = sel ? b_addr : a_addr;
  assign o_md   = sel ? b_md   : a_md;
  assign o_rd   = sel ? b_rd   : a_rd;
  assign o_save = sel ? b_save : a_save;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_done = sel ? b_done : a_done;
  assign o_und  = sel ? b_und  : a_und;

  always @(negedge clk) begin
    if (o_save === 1'b1) save_cnt++;
    if (o_done === 1'b1) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit hit, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0; mem_ready = 1'b0; read_pixel = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic pulse_start;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
  endtask

  // Called in the mem_rd cycle; returns in the save cycle with what was observed there.
  task automatic serve(input logic [31:0] d, input int lat, input logic poke,
                       output logic sv, output logic [31:0] md);
    tick();
    if (poke) begin
      if (sel) start_b = 1'b1; else start_a = 1'b1;
    end
    repeat (lat - 1) begin
      tick();
      start_a = 1'b0; start_b = 1'b0;
    end
    mem_ready = 1'b1; mem_data_in = d;
    tick();
    start_a = 1'b0; start_b = 1'b0; mem_ready = 1'b0;
    sv = o_save; md = o_md;
  endtask

  // Reads n pixels; flags any done pulse or mem_rd seen during those cycles.
  task automatic read_n(input int n, output logic saw_done, output logic saw_rd);
    saw_done = 1'b0; saw_rd = 1'b0;
    for (int i = 0; i < n; i++) begin
      read_pixel = 1'b1;
      if (o_done !== 1'b0) saw_done = 1'b1;
      if (o_rd !== 1'b0) saw_rd = 1'b1;
      tick();
    end
    read_pixel = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0; mem_ready = 1'b0; read_pixel = 1'b0;
    mem_data_in = 32'd0;
    #12;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if ({o_rd, o_save, o_busy, o_done, o_und} !== 5'b0 || o_addr !== '0 || o_md !== 32'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: rd/save/busy/done/und=%b addr=%0h md=%h required all zero",
                 s, {o_rd, o_save, o_busy, o_done, o_und}, o_addr, o_md);
      end
    end
  endtask

  task automatic test_basic;
    logic sv, sd, sr, bad;
    logic [31:0] md;
    sel = 1'b0;
    do_reset();
    pulse_start();
    checks++;
    if (o_rd !== 1'b1 || o_addr !== 18'd0) begin
      errors++; $display("FAIL basic_rd0: rd=%b addr=%0h required rd=1 addr=0", o_rd, o_addr);
    end
    serve(32'haabbccdd, 1, 1'b0, sv, md);
    checks++;
    if (sv !== 1'b1 || md !== 32'haabbccdd) begin
      errors++; $display("FAIL basic_save0: save=%b data=%h required 1 aabbccdd", sv, md);
    end
    tick();
    checks++;
    if (o_rd !== 1'b1 || o_addr !== 18'd1) begin
      errors++; $display("FAIL basic_rd1: rd=%b addr=%0h required rd=1 addr=1", o_rd, o_addr);
    end
    serve(32'habcdef77, 1, 1'b0, sv, md);
    checks++;
    if (sv !== 1'b1 || md !== 32'habcdef77) begin
      errors++; $display("FAIL basic_save1: save=%b data=%h required 1 abcdef77", sv, md);
    end
    tick();
    bad = 1'b0;
    repeat (6) begin
      if (o_rd !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b1 || o_md !== 32'habcdef77) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL basic_drain_hold: rd/done/busy/data deviated, required rd=0 done=0 busy=1 data held");
    end
    read_n(8, sd, sr);
    checks++;
    if (sd || sr) begin
      errors++; $display("FAIL basic_early_done: done_seen=%b rd_seen=%b required 0 0", sd, sr);
    end
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: done=%b busy=%b required 1 0", o_done, o_busy);
    end
    tick();
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL basic_done_once: done=%b busy=%b required 0 0", o_done, o_busy);
    end
  endtask

  task automatic test_backpressure;
    logic sv, sd, sr, bad;
    logic [31:0] md;
    sel = 1'b1;
    do_reset();
    pulse_start();
    serve(32'h11111111, 1, 1'b0, sv, md);
    tick();
    serve(32'h22222222, 1, 1'b0, sv, md);
    tick();
    bad = 1'b0;
    repeat (6) begin
      if (o_rd !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL bp_stall: mem_rd seen at credit 8, required none");
    end
    read_n(4, sd, sr);
    checks++;
    if (sr) begin
      errors++; $display("FAIL bp_rd_early: mem_rd seen while credit > 4, required none");
    end
    checks++;
    if (o_rd !== 1'b1 || o_addr !== 18'd2) begin
      errors++; $display("FAIL bp_rd2: rd=%b addr=%0h required rd=1 addr=2", o_rd, o_addr);
    end
  endtask

  // Continues the frame left by test_backpressure: REQ, credit 4, mem_rd for word 2.
  task automatic test_simultaneous;
    logic sv, sd, sr, bad;
    logic [31:0] md;
    read_pixel = 1'b1;
    tick();
    mem_ready = 1'b1; mem_data_in = 32'h01020304;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (o_save !== 1'b1 || o_md !== 32'h01020304) begin
      errors++; $display("FAIL sim_save2: save=%b data=%h required 1 01020304", o_save, o_md);
    end
    tick();
    read_pixel = 1'b0;
    bad = (o_rd !== 1'b0);
    tick();
    if (o_rd !== 1'b0) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++; $display("FAIL sim_no_rd_at_5: mem_rd seen at credit 5, required none");
    end
    read_pixel = 1'b1;
    tick();
    read_pixel = 1'b0;
    checks++;
    if (o_rd !== 1'b1 || o_addr !== 18'd3) begin
      errors++; $display("FAIL sim_rd3: rd=%b addr=%0h required rd=1 addr=3", o_rd, o_addr);
    end
    serve(32'h0a0b0c0d, 2, 1'b0, sv, md);
    checks++;
    if (sv !== 1'b1 || md !== 32'h0a0b0c0d) begin
      errors++; $display("FAIL sim_save3: save=%b data=%h required 1 0a0b0c0d", sv, md);
    end
    tick();
    read_n(8, sd, sr);
    checks++;
    if (sd || sr || o_done !== 1'b1) begin
      errors++; $display("FAIL sim_last_word: early_done=%b rd_seen=%b done=%b required 0 0 1", sd, sr, o_done);
    end
  endtask

  task automatic test_underrun;
    logic sv, sd, sr;
    logic [31:0] md;
    sel = 1'b0;
    do_reset();
    pulse_start();
    tick();
    read_pixel = 1'b1;
    tick();
    read_pixel = 1'b0;
    checks++;
    if (o_und !== 1'b1) begin
      errors++; $display("FAIL und_set: underrun=%b required 1", o_und);
    end
    repeat (3) tick();
    mem_ready = 1'b1; mem_data_in = 32'hc0ffee00;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (o_save !== 1'b1 || o_md !== 32'hc0ffee00) begin
      errors++; $display("FAIL und_slow_save: save=%b data=%h required 1 c0ffee00", o_save, o_md);
    end
    tick();
    checks++;
    if (o_rd !== 1'b1 || o_addr !== 18'd1) begin
      errors++; $display("FAIL und_rd1: rd=%b addr=%0h required rd=1 addr=1", o_rd, o_addr);
    end
    serve(32'h55aa55aa, 1, 1'b0, sv, md);
    tick();
    read_n(8, sd, sr);
    checks++;
    if (sd || o_done !== 1'b1) begin
      errors++; $display("FAIL und_credit_zero: early_done=%b done=%b required 0 1", sd, o_done);
    end
    tick();
    checks++;
    if (o_und !== 1'b1) begin
      errors++; $display("FAIL und_sticky: underrun=%b required 1", o_und);
    end
    pulse_start();
    checks++;
    if (o_und !== 1'b0 || o_rd !== 1'b1) begin
      errors++; $display("FAIL und_clear: underrun=%b rd=%b required 0 1", o_und, o_rd);
    end
  endtask

  // Continues from test_underrun: a new frame just issued mem_rd for word 0.
  task automatic test_reset_mid;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({o_rd, o_save, o_busy, o_done} !== 4'b0 || o_md !== 32'd0) begin
      errors++; $display("FAIL rst_async: rd/save/busy/done=%b data=%h required 0000 00000000",
                         {o_rd, o_save, o_busy, o_done}, o_md);
    end
    tick();
    reset = 1'b1;
    tick();
    mem_ready = 1'b1; mem_data_in = 32'hdeadbeef;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (o_save !== 1'b0 || o_busy !== 1'b0 || o_md !== 32'd0 || o_rd !== 1'b0) begin
      errors++; $display("FAIL rst_late_ready: save=%b busy=%b rd=%b data=%h required 0 0 0 00000000",
                         o_save, o_busy, o_rd, o_md);
    end
  endtask

  task automatic test_start_busy;
    logic sv, sd, sr;
    logic [31:0] md;
    logic [AW-1:0] seen [4];
    sel = 1'b1;
    do_reset();
    save_cnt = 0; done_cnt = 0;
    pulse_start();
    seen[0] = o_rd ? o_addr : '1;
    serve(32'h00000001, 3, 1'b1, sv, md);
    tick();
    seen[1] = o_rd ? o_addr : '1;
    serve(32'h00000002, 1, 1'b1, sv, md);
    tick();
    read_n(4, sd, sr);
    seen[2] = o_rd ? o_addr : '1;
    serve(32'h00000003, 2, 1'b0, sv, md);
    tick();
    read_n(4, sd, sr);
    seen[3] = o_rd ? o_addr : '1;
    serve(32'h00000004, 1, 1'b0, sv, md);
    tick();
    read_n(8, sd, sr);
    repeat (4) tick();
    checks++;
    if (seen[0] !== 18'd0 || seen[1] !== 18'd1 || seen[2] !== 18'd2 || seen[3] !== 18'd3) begin
      errors++; $display("FAIL sb_addr_seq: got %0h %0h %0h %0h required 0 1 2 3",
                         seen[0], seen[1], seen[2], seen[3]);
    end
    checks++;
    if (save_cnt != 4 || done_cnt != 1) begin
      errors++; $display("FAIL sb_counts: saves=%0d dones=%0d required 4 1", save_cnt, done_cnt);
    end
    checks++;
    if (o_busy !== 1'b0 || o_md !== 32'h00000004) begin
      errors++; $display("FAIL sb_end: busy=%b data=%h required 0 00000004", o_busy, o_md);
    end
  endtask

  initial begin
    sel = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_simultaneous();
    test_underrun();
    test_reset_mid();
    test_start_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
